kmeans_point_feeder: RTL and testbench

Drives the accumulator side of the k-means datapath. Buffers a dataset of d-dimensional 32-bit points loaded over a valid/ready port, then runs a programmed number of k-means iterations. Each iteration clears the accumulator, streams every buffered point with one `acc` strobe per point, issues a `swap` so the accumulator computes new centroids, and waits for them to settle. It owns iteration sequencing for the top level; the accumulator itself stays a passive datapath.

---
 rtl/kmeans_point_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_kmeans_point_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_point_feeder.sv
// -----------------------------------------------------------------------------
// kmeans_point_feeder
//
// Buffers a dataset of d-dimensional 32-bit points and sequences k-means
// iterations for a passive accumulator. Each iteration clears the accumulator,
// streams every buffered point (one acc strobe per point, no gaps), issues a
// swap strobe and waits one settle cycle for the new centroids.
//
// Optional feature macro: KMEANS_FEEDER_CONV_EN
//   Defined   : adds cent_cur/cent_new inputs. A run stops early when the new
//               centroids equal the current ones (never on iteration 0).
//   Undefined : converged is tied low and every run executes niter iterations.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   ld_valid     load beat valid
//   ld_ready     feeder can accept a load beat (idle and buffer not full)
//   ld_point     point appended at address count
//   ld_clear     empty the buffer (idle only, wins over a simultaneous beat)
//   niter        iterations to run, sampled at start
//   start        begin a run (idle only)
//   busy         run in progress
//   done         one-cycle pulse at run end
//   first_iter   high during iteration 0
//   acc_rst      accumulator clear pulse
//   acc_point    point presented to the accumulator
//   acc          accumulate strobe
//   swap         centroid update strobe
//   iter_cnt     completed iterations
//   count        points buffered
//   converged    early-stop flag
//   cent_cur     current centroids (feature only)
//   cent_new     candidate centroids (feature only)
// -----------------------------------------------------------------------------
module kmeans_point_feeder #(
   parameter int unsigned n = 8,
   parameter int unsigned d = 2,
   parameter int unsigned P = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [d-1:0][31:0]    ld_point,
   input  logic                  ld_clear,
   input  logic [15:0]           niter,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  first_iter,
   output logic                  acc_rst,
   output logic [d-1:0][31:0]    acc_point,
   output logic                  acc,
   output logic                  swap,
   output logic [15:0]           iter_cnt,
   output logic [P:0]            count,
`ifdef KMEANS_FEEDER_CONV_EN
   input  logic [(2**n)-1:0][d-1:0][31:0] cent_cur,
   input  logic [(2**n)-1:0][d-1:0][31:0] cent_new,
`endif
   output logic                  converged
);

   localparam logic [P:0] One = {{P{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StPrime,
      StStream,
      StSwap,
      StSettle,
      StFin
   } state_t;

   state_t            state;
   logic [15:0]       niter_q;
   logic [P:0]        str_cnt;   // doubles as read address (low P bits)
   logic              wr_en;
   logic [P:0]        count_nxt;
   logic              conv_hit;

   logic [d-1:0][31:0] mem [2**P];

   // Load-side bookkeeping; only active while idle so the buffer is frozen
   // for the whole run.
   always_comb begin
      wr_en     = 1'b0;
      count_nxt = count;
      if (state == StIdle) begin
         if (ld_clear) begin
            count_nxt = '0;
         end else if (ld_valid && ld_ready) begin
            wr_en     = 1'b1;
            count_nxt = count + One;
         end
      end
   end

`ifdef KMEANS_FEEDER_CONV_EN
   always_comb begin
      conv_hit = (cent_new == cent_cur) && !first_iter;
   end
`else
   logic unused_n;
   assign unused_n = ^n;

   always_comb begin
      conv_hit = 1'b0;
   end
`endif

   // Point buffer, kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[count[P-1:0]] <= ld_point;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         ld_ready   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         first_iter <= 1'b0;
         acc_rst    <= 1'b0;
         acc        <= 1'b0;
         swap       <= 1'b0;
         acc_point  <= '0;
         iter_cnt   <= '0;
         count      <= '0;
         converged  <= 1'b0;
         niter_q    <= '0;
         str_cnt    <= '0;
      end else begin
         done    <= 1'b0;
         acc_rst <= 1'b0;
         swap    <= 1'b0;
         count   <= count_nxt;
         unique case (state)
            StIdle: begin
               // count_nxt[P] is set only when the buffer is exactly full
               ld_ready <= !count_nxt[P];
               if (start) begin
                  ld_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (count_nxt != '0 && niter != '0) begin
                     niter_q    <= niter;
                     iter_cnt   <= '0;
                     converged  <= 1'b0;
                     first_iter <= 1'b1;
                     acc_rst    <= 1'b1;
                     state      <= StClr;
                  end else begin
                     // Nothing to do: report completion without strobes.
                     done  <= 1'b1;
                     state <= StFin;
                  end
               end
            end
            StClr: begin
               str_cnt <= '0;
               state   <= StPrime;
            end
            StPrime: begin
               acc_point <= mem[str_cnt[P-1:0]];
               str_cnt   <= str_cnt + One;
               acc       <= 1'b1;
               state     <= StStream;
            end
            StStream: begin
               // str_cnt counts points already handed to acc_point
               if (str_cnt == count) begin
                  acc   <= 1'b0;
                  swap  <= 1'b1;
                  state <= StSwap;
               end else begin
                  acc_point <= mem[str_cnt[P-1:0]];
                  str_cnt   <= str_cnt + One;
               end
            end
            StSwap: begin
               state <= StSettle;
            end
            StSettle: begin
               iter_cnt   <= iter_cnt + 16'd1;
               first_iter <= 1'b0;
               if ((iter_cnt + 16'd1 == niter_q) || conv_hit) begin
                  converged <= conv_hit;
                  done      <= 1'b1;
                  state     <= StFin;
               end else begin
                  acc_rst <= 1'b1;
                  state   <= StClr;
               end
            end
            StFin: begin
               busy     <= 1'b0;
               ld_ready <= !count[P];
               state    <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kmeans_point_feeder.sv
// -----------------------------------------------------------------------------
// tb_kmeans_point_feeder
//
// Self-checking bench for kmeans_point_feeder (n=1, d=2, P=2: four-point
// buffer). A cycle-level model derives every output from the run's start
// cycle, point count and iteration count; a negedge process compares the DUT
// against it each cycle. Directed scenarios add literal spot checks.
// Define KMEANS_FEEDER_CONV_EN to also exercise the early-stop feature.
// -----------------------------------------------------------------------------
module tb_kmeans_point_feeder;

   localparam int Cap = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_valid;
   logic              ld_ready;
   logic [1:0][31:0]  ld_point;
   logic              ld_clear;
   logic [15:0]       niter;
   logic              start;
   logic              busy;
   logic              done;
   logic              first_iter;
   logic              acc_rst;
   logic [1:0][31:0]  acc_point;
   logic              acc;
   logic              swap;
   logic [15:0]       iter_cnt;
   logic [2:0]        count;
   logic              converged;
`ifdef KMEANS_FEEDER_CONV_EN
   logic [1:0][1:0][31:0] cent_cur;
   logic [1:0][1:0][31:0] cent_new;
`endif

   kmeans_point_feeder #(
      .n (1),
      .d (2),
      .P (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_point   (ld_point),
      .ld_clear   (ld_clear),
      .niter      (niter),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .first_iter (first_iter),
      .acc_rst    (acc_rst),
      .acc_point  (acc_point),
      .acc        (acc),
      .swap       (swap),
      .iter_cnt   (iter_cnt),
      .count      (count),
`ifdef KMEANS_FEEDER_CONV_EN
      .cent_cur   (cent_cur),
      .cent_new   (cent_new),
`endif
      .converged  (converged)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, exp);
   endtask

   // ---------------------------------------------------------------- model
   logic [1:0][31:0] m_mem [Cap];
   int   m_count = 0;
   int   m_iter = 0;
   bit   m_conv = 1'b0;
   bit   run_on = 1'b0;
   int   run_s, run_n, run_total, run_iter_end;
   bit   run_conv_end;
   int   conv_iters = 0;   // >0: the run is expected to stop early after this many
   bit   chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         int r, per, i, ph, pt, nc;
         bit e_busy, e_done, e_arst, e_acc, e_swap, e_first, e_ready, e_conv;
         int e_iter;
         e_busy = 0; e_done = 0; e_arst = 0; e_acc = 0; e_swap = 0; e_first = 0;
         e_ready = (m_count < Cap); e_conv = m_conv; e_iter = m_iter; pt = 0;
         if (run_on) begin
            r = cyc - run_s;
            per = run_n + 4;
            e_ready = 0;
            e_busy = 1;
            if (r == run_total) begin
               e_done = 1;
               e_iter = run_iter_end;
               e_conv = run_conv_end;
            end else begin
               i = (r - 1) / per;
               ph = (r - 1) % per;
               e_iter = i;
               e_conv = 0;
               e_first = (i == 0);
               e_arst = (ph == 0);
               e_acc = (ph >= 2) && (ph <= run_n + 1);
               e_swap = (ph == run_n + 2);
               pt = ph - 2;
            end
         end
         chk("busy", 64'(busy), 64'(e_busy));
         chk("done", 64'(done), 64'(e_done));
         chk("acc_rst", 64'(acc_rst), 64'(e_arst));
         chk("acc", 64'(acc), 64'(e_acc));
         chk("swap", 64'(swap), 64'(e_swap));
         chk("first_iter", 64'(first_iter), 64'(e_first));
         chk("ld_ready", 64'(ld_ready), 64'(e_ready));
         chk("iter_cnt", 64'(iter_cnt), 64'(e_iter));
         chk("count", 64'(count), 64'(m_count));
         chk("converged", 64'(converged), 64'(e_conv));
         if (e_acc) chk("acc_point", 64'(acc_point), 64'(m_mem[pt]));

         // advance model with this cycle's inputs
         if (rst) begin
            m_count = 0; m_iter = 0; m_conv = 0; run_on = 0;
         end else if (run_on) begin
            if (cyc - run_s == run_total) begin
               run_on = 0;
               m_iter = run_iter_end;
               m_conv = run_conv_end;
            end
         end else begin
            nc = m_count;
            if (ld_clear) nc = 0;
            else if (ld_valid && m_count < Cap) begin
               m_mem[m_count] = ld_point;
               nc = m_count + 1;
            end
            m_count = nc;
            if (start) begin
               run_on = 1;
               run_s = cyc;
               if (nc != 0 && niter != 0) begin
                  run_n = nc;
                  run_iter_end = (conv_iters > 0) ? conv_iters : int'(niter);
                  run_total = run_iter_end * (nc + 4) + 1;
                  run_conv_end = (conv_iters > 0);
               end else begin
                  run_total = 1;
                  run_iter_end = m_iter;
                  run_conv_end = m_conv;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at(input int c);
      while (cyc < c) tick();
   endtask

   task automatic load(input int x, input int y);
      ld_valid = 1'b1;
      ld_point = {32'(y), 32'(x)};
      tick();
      ld_valid = 1'b0;
   endtask

   int c0;

   initial begin
      rst = 1'b1; ld_valid = 1'b0; ld_point = '0; ld_clear = 1'b0;
      niter = '0; start = 1'b0;
`ifdef KMEANS_FEEDER_CONV_EN
      cent_cur = '0; cent_new = '0;
`endif
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("reset ld_ready", 64'(ld_ready), 64'd1);
      chk("reset acc_point", 64'(acc_point), 64'd0);
      chk("reset count", 64'(count), 64'd0);

      // three points, two iterations
      load(1, 2); load(3, 4); load(5, 6);
      niter = 16'd2; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
      chk("t2 acc_rst@1", 64'(acc_rst), 64'd1);
      at(c0 + 3);
      chk("t2 acc@3", 64'(acc), 64'd1);
      chk("t2 point0", 64'(acc_point), {32'd2, 32'd1});
      at(c0 + 5);
      chk("t2 point2", 64'(acc_point), {32'd6, 32'd5});
      at(c0 + 6);
      chk("t2 swap@6", 64'(swap), 64'd1);
      at(c0 + 8);
      chk("t2 acc_rst@8", 64'(acc_rst), 64'd1);
      at(c0 + 13);
      chk("t2 swap@13", 64'(swap), 64'd1);
      at(c0 + 15);
      chk("t2 done@15", 64'(done), 64'd1);
      chk("t2 iter_cnt", 64'(iter_cnt), 64'd2);
      tick();

      // fill to capacity, overflow beat must be dropped
      ld_clear = 1'b1; tick(); ld_clear = 1'b0;
      load(10, 11); load(12, 13); load(14, 15); load(16, 17);
      chk("full ld_ready", 64'(ld_ready), 64'd0);
      chk("full count", 64'(count), 64'd4);
      load(99, 98);
      chk("overflow count", 64'(count), 64'd4);
      niter = 16'd1; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
      at(c0 + 3);
      chk("full point0 intact", 64'(acc_point), {32'd11, 32'd10});
      at(c0 + 9);
      chk("full done", 64'(done), 64'd1);
      tick();

      // clear wins over a simultaneous beat
      ld_clear = 1'b1; tick(); ld_clear = 1'b0;
      load(7, 7);
      chk("one point", 64'(count), 64'd1);
      ld_clear = 1'b1; ld_valid = 1'b1; ld_point = {32'd8, 32'd8};
      tick();
      ld_clear = 1'b0; ld_valid = 1'b0;
      chk("clear priority", 64'(count), 64'd0);

      // empty buffer: immediate done, no strobes
      niter = 16'd3; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
      chk("empty done", 64'(done), 64'd1);
      chk("empty acc_rst", 64'(acc_rst), 64'd0);
      repeat (3) tick();

      // reset on the second stream cycle
      load(1, 2); load(3, 4); load(5, 6);
      niter = 16'd1; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
      at(c0 + 4);
      chk("pre-rst acc", 64'(acc), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst acc", 64'(acc), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst count", 64'(count), 64'd0);
      tick();

`ifdef KMEANS_FEEDER_CONV_EN
      // centroids stop moving after iteration 0: stop after two iterations
      load(1, 2); load(3, 4); load(5, 6);
      cent_cur = {32'd4, 32'd3, 32'd2, 32'd1};
      cent_new = {32'd9, 32'd9, 32'd9, 32'd9};
      conv_iters = 2;
      niter = 16'd10; start = 1'b1; c0 = cyc; tick(); start = 1'b0;
      at(c0 + 8);
      cent_new = cent_cur;
      at(c0 + 15);
      chk("conv done", 64'(done), 64'd1);
      chk("conv flag", 64'(converged), 64'd1);
      chk("conv iter_cnt", 64'(iter_cnt), 64'd2);
      tick();
      conv_iters = 0;
`endif

      repeat (3) tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
